dom_share_gen: RTL
==================

DOM_SHARE_GEN -- requirements
Module: dom_share_gen

Interface
REQ-001 Parameter LFSR_W, default 32, width of the mask PRNG state.
REQ-002 Parameter DEF_SEED, default 32'hACE1_2468, seed loaded at reset and substituted for an all-zero seed.
REQ-003 Parameter RESEED_INT, default 1024, number of accepted transactions after which reseed_req asserts.
REQ-004 Parameter REQUIRE_SEED, default 1; when 1, no transaction is accepted after reset until a seed is loaded.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 seed_valid  input  1  seed offer.
REQ-008 seed_data  input  LFSR_W  seed value.
REQ-009 seed_ready  output  1  seed accepted this cycle when high together with seed_valid.
REQ-010 in_valid  input  1  unmasked operand pair present.
REQ-011 in_ready  output  1  block accepts the operand pair this cycle.
REQ-012 a, b  input  1 each  unmasked operands.
REQ-013 out_valid  input-side of dom_mult  output  1  share set valid.
REQ-014 out_ready  input  1  downstream dom_mult consumes the share set.
REQ-015 Ax, Ay, Bx, By  output  1 each  two-share masked operands for dom_mult.
REQ-016 Z0  output  1  fresh DOM resharing randomness for dom_mult.
REQ-017 reseed_req  output  1  sticky request for a new seed.

Function
REQ-018 Randomness r[2:0] = lfsr[2:0]; mA=r[0], mB=r[1], z=r[2].
REQ-019 LFSR is Fibonacci, polynomial x^32+x^22+x^2+x+1, advanced exactly 3 steps per accepted transaction, never otherwise; each bit is used once.
REQ-020 On acceptance (in_valid && in_ready): Ax<=a^mA, Ay<=mA, Bx<=b^mB, By<=mB, Z0<=z, out_valid<=1; latency one cycle.
REQ-021 in_ready = (state==RUN) && (!out_valid || out_ready); back-to-back throughput one per cycle.
REQ-022 While out_valid && !out_ready, Ax/Ay/Bx/By/Z0 hold stable; no output bit changes without a handshake.
REQ-023 out_valid clears on out_ready when no new acceptance occurs in the same cycle.
REQ-024 States: SEED_WAIT, RUN, DRAIN.
REQ-025 SEED_WAIT: seed_ready=1; on seed_valid load seed, go RUN.
REQ-026 RUN: seed_valid high moves to DRAIN; in_ready=0 from that cycle.
REQ-027 DRAIN: in_ready=0; seed_ready=1 only when out_valid=0 (or cleared this cycle); on seed load go RUN.
REQ-028 A seed equal to zero loads DEF_SEED instead.
REQ-029 Transaction counter increments per acceptance, saturates at RESEED_INT; reseed_req=1 when count==RESEED_INT; seed load clears counter and reseed_req.
REQ-030 reseed_req is advisory; acceptance continues when asserted.
REQ-031 No combinational path from a or b to any output.

Reset
REQ-032 While rstn=0: lfsr=DEF_SEED, counter=0, out_valid=0, Ax=Ay=Bx=By=Z0=0, reseed_req=0.
REQ-033 Reset state is SEED_WAIT if REQUIRE_SEED=1, else RUN.
REQ-034 Reset mid-transaction discards the held share set; no partial output survives.

Structure
REQ-035 Shared package dom_pkg holds the state enum, LFSR tap constants and DEF_SEED default.
REQ-036 One sub-module dom_lfsr: LFSR register with load, zero-substitution and 3-step advance enable.

Verification
REQ-037 Reset, REQUIRE_SEED=1, in_valid=1 for 10 cycles -> in_ready=0, out_valid=0, all shares 0.
REQ-038 Seed 32'h0000_0001, then all 4 {a,b} combinations -> Ax^Ay==a, Bx^By==b each cycle; dom_mult Aq^Bq==a&b one cycle later.
REQ-039 out_ready=0 for 5 cycles with out_valid=1 -> Ax/Ay/Bx/By/Z0 unchanged; lfsr unchanged.
REQ-040 Seed 32'h0 -> lfsr equals 32'hACE1_2468; following outputs match a golden model seeded 32'hACE1_2468.
REQ-041 RESEED_INT=4, 4 acceptances -> reseed_req=1 after 4th; 5th still accepted; seed load clears it.
REQ-042 seed_valid in RUN with held output and out_ready=0 for 3 cycles -> DRAIN, seed_ready=0 until the held set is consumed, then seed loads and RUN resumes.

Source files
------------

// File: rtl/dom_pkg.sv
// Shared definitions for the DOM share generator.
//   dom_state_e   : control states of the share generator
//   LFSR_TAP_*    : lower feedback taps of x^32+x^22+x^2+x+1 (the top term is
//                   always the MSB of the register)
//   LFSR_STEPS    : PRNG steps consumed per accepted transaction
//   DOM_DEF_SEED  : default seed, also used in place of an all-zero seed
package dom_pkg;

  typedef enum logic [1:0] {
    SEED_WAIT = 2'd0,
    RUN       = 2'd1,
    DRAIN     = 2'd2
  } dom_state_e;

  localparam int unsigned LFSR_TAP_22 = 21;
  localparam int unsigned LFSR_TAP_2  = 1;
  localparam int unsigned LFSR_TAP_1  = 0;
  localparam int unsigned LFSR_STEPS  = 3;

  localparam logic [31:0] DOM_DEF_SEED = 32'hACE1_2468;

endpackage

// File: rtl/dom_lfsr.sv
// Mask PRNG for the DOM share generator: Fibonacci LFSR, shift-left form.
//   clk, rstn : clock, asynchronous active-low reset (state <= DEF_SEED)
//   load_i    : load seed_i (all-zero seed replaced by DEF_SEED)
//   seed_i    : seed value
//   adv_i     : advance LFSR_STEPS steps (three fresh bits per transaction)
//   rnd_o     : current low three state bits, {z, mB, mA}
module dom_lfsr
  import dom_pkg::*;
#(
  parameter int unsigned       W        = 32,
  parameter logic [W-1:0]      DEF_SEED = W'(DOM_DEF_SEED)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         adv_i,
  output logic [2:0]   rnd_o
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;
  logic [W-1:0] adv_val;

  // One Fibonacci step: feedback from x^32, x^22, x^2, x^1 enters at bit 0.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    logic fb;
    fb = s[W-1] ^ s[LFSR_TAP_22] ^ s[LFSR_TAP_2] ^ s[LFSR_TAP_1];
    return {s[W-2:0], fb};
  endfunction

  // Three steps shift the consumed bits [2:0] up and out of the tap window of
  // the next draw, so every drawn bit is fresh.
  always_comb begin
    adv_val = state_q;
    for (int i = 0; i < int'(LFSR_STEPS); i++) begin
      adv_val = lfsr_step(adv_val);
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      // An all-zero state would lock the LFSR up.
      state_d = (seed_i == '0) ? DEF_SEED : seed_i;
    end else if (adv_i) begin
      state_d = adv_val;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DEF_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign rnd_o = state_q[2:0];

endmodule

// File: rtl/dom_share_gen.sv
// DOM share generator: masks an unmasked operand pair (a, b) into two-share
// form and supplies one fresh resharing bit for a downstream dom_mult.
//   clk, rstn              : clock, asynchronous active-low reset
//   seed_valid/seed_ready  : seed handshake, seed_data is the LFSR seed
//   in_valid/in_ready, a,b : operand handshake
//   out_valid/out_ready    : share-set handshake towards dom_mult
//   Ax, Ay, Bx, By         : shares with Ax^Ay == a, Bx^By == b
//   Z0                     : fresh resharing randomness
//   reseed_req             : sticky advisory request for a new seed
module dom_share_gen
  import dom_pkg::*;
#(
  parameter int unsigned       LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] DEF_SEED     = LFSR_W'(DOM_DEF_SEED),
  parameter int unsigned       RESEED_INT   = 1024,
  parameter bit                REQUIRE_SEED = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed_data,
  output logic              seed_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              a,
  input  logic              b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              Ax,
  output logic              Ay,
  output logic              Bx,
  output logic              By,
  output logic              Z0,
  output logic              reseed_req
);

  localparam int unsigned CNT_W = $clog2(RESEED_INT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESEED_INT);
  localparam dom_state_e RST_STATE = REQUIRE_SEED ? SEED_WAIT : RUN;

  dom_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [4:0]       shares_q, shares_d;   // {Ax, Ay, Bx, By, Z0}
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       accept;
  logic       seed_load;
  logic       out_free;
  logic [2:0] rnd;
  logic       m_a, m_b, z;

  dom_lfsr #(
    .W        (LFSR_W),
    .DEF_SEED (DEF_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (seed_load),
    .seed_i (seed_data),
    .adv_i  (accept),
    .rnd_o  (rnd)
  );

  assign m_a = rnd[0];
  assign m_b = rnd[1];
  assign z   = rnd[2];

  // Output slot is free when empty or being consumed this cycle.
  assign out_free = !out_valid_q || out_ready;

  // A seed offer in RUN blocks new operands in the same cycle so the drain
  // towards a reseed starts immediately.
  assign in_ready   = (state_q == RUN) && !seed_valid && out_free;
  assign seed_ready = (state_q == SEED_WAIT) || ((state_q == DRAIN) && out_free);

  assign accept    = in_valid && in_ready;
  assign seed_load = seed_valid && seed_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEED_WAIT: if (seed_load)  state_d = RUN;
      RUN:       if (seed_valid) state_d = DRAIN;
      DRAIN:     if (seed_load)  state_d = RUN;
      default:                   state_d = RST_STATE;
    endcase
  end

  always_comb begin
    shares_d    = shares_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      shares_d    = {a ^ m_a, m_a, b ^ m_b, m_b, z};
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (seed_load) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RST_STATE;
      out_valid_q <= 1'b0;
      shares_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      shares_q    <= shares_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign Ax         = shares_q[4];
  assign Ay         = shares_q[3];
  assign Bx         = shares_q[2];
  assign By         = shares_q[1];
  assign Z0         = shares_q[0];
  assign reseed_req = (cnt_q == CNT_MAX);

endmodule
